robs_divider: RTL and testbench

Sequential signed integer divider, the inverse operation of the Robertson's signed multiplier datapath. It accepts a two's-complement dividend and divisor on a start strobe and computes the quotient and remainder by iterative non-restoring division, one quotient bit per clock. Control FSM and datapath are in one module, and it sits beside the multiplier on the same operand buses. Division truncates toward zero, the remainder takes the sign of the dividend, and divide-by-zero and overflow are flagged.

---
 rtl/robs_divider.sv | 161 ++++++++++++++++
 tb/tb_robs_divider.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/robs_divider.sv
// robs_divider: sequential signed integer divider, one quotient bit per clock
// (non-restoring). The quotient truncates toward zero and the remainder takes
// the sign of the dividend. Divide-by-zero and most-negative / -1 overflow are
// flagged.
// Optional feature macro: ROBS_DIV_ONE_FAST_EN. When it is defined, a divisor
// of +1 or -1 bypasses the iteration loop.
module robs_divider #(
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] dividend,
   input  logic signed [WIDTH-1:0] divisor,
   output logic signed [WIDTH-1:0] quotient,
   output logic signed [WIDTH-1:0] remainder,
   output logic                    busy,
   output logic                    done,
   output logic                    dbz,
   output logic                    ovf
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ITER,
      S_FIX,
      S_SIGN,
      S_DONE
   } state_t;

   state_t                 state;
   logic signed [WIDTH-1:0] dvd_r;
   logic signed [WIDTH-1:0] dsr_r;
   logic [WIDTH-1:0]        m_r;
   logic [WIDTH-1:0]        q_r;
   logic signed [WIDTH:0]   a_r;
   logic [CW-1:0]           cnt;
   logic                    div0;

   logic signed [WIDTH:0]   m_ext;
   logic signed [WIDTH:0]   a_sh;
   logic signed [WIDTH:0]   a_nx;

   // Two's-complement negation at WIDTH bits.
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
      return (~x) + ONE;
   endfunction

   // Magnitude as a WIDTH-bit unsigned value. The most-negative input maps to 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? neg_w(x) : x;
   endfunction

   assign m_ext = $signed({1'b0, m_r});

   // One non-restoring step: shift {A,Q} left, then add or subtract M by the old sign of A.
   always_comb begin
      a_sh = $signed({a_r[WIDTH-1:0], q_r[WIDTH-1]});
      a_nx = a_sh;
      if (a_r[WIDTH])
         a_nx = a_sh + m_ext;
      else
         a_nx = a_sh - m_ext;
   end

   // Control FSM and datapath registers. Results load in SIGN and hold until the next accepted start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         dvd_r     <= '0;
         dsr_r     <= '0;
         m_r       <= '0;
         q_r       <= '0;
         a_r       <= '0;
         cnt       <= '0;
         div0      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         dbz       <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  dvd_r <= dividend;
                  dsr_r <= divisor;
                  div0  <= 1'b0;
                  dbz   <= 1'b0;
                  ovf   <= 1'b0;
                  busy  <= 1'b1;
                  state <= S_LOAD;
               end else begin
                  state <= S_IDLE;
               end
            end

            S_LOAD: begin
               m_r <= abs_w(dsr_r);
               q_r <= abs_w(dvd_r);
               a_r <= '0;
               cnt <= CW'(WIDTH);
               if (dsr_r == '0) begin
                  // Special cases bypass the loop and load their results in SIGN.
                  div0  <= 1'b1;
                  state <= S_SIGN;
               end
`ifdef ROBS_DIV_ONE_FAST_EN
               else if (abs_w(dsr_r) == ONE) begin
                  // With A = 0 and Q = |dividend|, SIGN produces +/-dividend remainder 0.
                  state <= S_SIGN;
               end
`endif
               else begin
                  state <= S_ITER;
               end
            end

            S_ITER: begin
               a_r <= a_nx;
               q_r <= {q_r[WIDTH-2:0], ~a_nx[WIDTH]};
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1))
                  state <= S_FIX;
            end

            S_FIX: begin
               if (a_r[WIDTH])
                  a_r <= a_r + m_ext;
               state <= S_SIGN;
            end

            S_SIGN: begin
               if (div0) begin
                  quotient  <= '1;
                  remainder <= dvd_r;
                  dbz       <= 1'b1;
                  ovf       <= 1'b0;
               end else begin
                  quotient  <= (dvd_r[WIDTH-1] ^ dsr_r[WIDTH-1]) ? neg_w(q_r) : q_r;
                  remainder <= dvd_r[WIDTH-1] ? neg_w(a_r[WIDTH-1:0]) : a_r[WIDTH-1:0];
                  ovf       <= (dvd_r == MOST_NEG) && (dsr_r == '1);
               end
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_DONE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_robs_divider.sv
// Directed testbench for robs_divider (WIDTH = 8).
module tb_robs_divider;

   logic              clk;
   logic              reset;
   logic              start;
   logic signed [7:0] dividend;
   logic signed [7:0] divisor;
   logic signed [7:0] quotient;
   logic signed [7:0] remainder;
   logic              busy;
   logic              done;
   logic              dbz;
   logic              ovf;

   int nvec;
   int nerr;

`ifdef ROBS_DIV_ONE_FAST_EN
   localparam int LAT_ONE = 2;
`else
   localparam int LAT_ONE = 11;
`endif

   robs_divider #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy),
      .done      (done),
      .dbz       (dbz),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Start one operation and return the cycle count from the accept edge to done (-1 on timeout).
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat, output logic busy_acc);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      busy_acc = busy;
      lat      = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      nvec++;
      if ({quotient, remainder, busy, done, dbz, ovf} !== 20'h0) begin
         nerr++;
         $display("FAIL reset_state: got q=%h r=%h busy=%b done=%b dbz=%b ovf=%b, want all 0",
                  quotient, remainder, busy, done, dbz, ovf);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_divide();
      logic [7:0] va [6];
      logic [7:0] vb [6];
      logic [7:0] eq [6];
      logic [7:0] er [6];
      int lat;
      logic bz;
      // 100/7, -100/7, 100/-7, 7/100, -7/2, 127/127
      va = '{8'd100, 8'h9C, 8'd100, 8'd7,   8'hF9, 8'd127};
      vb = '{8'd7,   8'd7,  8'hF9,  8'd100, 8'd2,  8'd127};
      eq = '{8'h0E,  8'hF2, 8'hF2,  8'h00,  8'hFD, 8'h01};
      er = '{8'h02,  8'hFE, 8'h02,  8'h07,  8'hFF, 8'h00};
      for (int i = 0; i < 6; i++) begin
         run_op(va[i], vb[i], lat, bz);
         nvec++;
         if (quotient !== eq[i] || remainder !== er[i] || dbz !== 1'b0 || ovf !== 1'b0) begin
            nerr++;
            $display("FAIL divide_%0d: got q=%h r=%h dbz=%b ovf=%b, want q=%h r=%h dbz=0 ovf=0",
                     i, quotient, remainder, dbz, ovf, eq[i], er[i]);
         end
         nvec++;
         if (lat !== 11 || bz !== 1'b1) begin
            nerr++;
            $display("FAIL divide_lat_%0d: got latency=%0d busy_at_accept=%b, want 11 and 1", i, lat, bz);
         end
      end
      nvec++;
      if (busy !== 1'b0) begin
         nerr++;
         $display("FAIL busy_at_done: got %b, want 0", busy);
      end
   endtask

   task automatic test_dbz();
      int lat;
      logic bz;
      run_op(8'd100, 8'd0, lat, bz);
      nvec++;
      if (quotient !== 8'hFF || remainder !== 8'h64 || dbz !== 1'b1 || ovf !== 1'b0 || lat !== 2) begin
         nerr++;
         $display("FAIL dbz: got q=%h r=%h dbz=%b ovf=%b lat=%0d, want q=ff r=64 dbz=1 ovf=0 lat=2",
                  quotient, remainder, dbz, ovf, lat);
      end
      // Results hold; on the next accept dbz clears but the old result stays.
      repeat (3) @(posedge clk);
      #1;
      nvec++;
      if (quotient !== 8'hFF || dbz !== 1'b1) begin
         nerr++;
         $display("FAIL dbz_hold: got q=%h dbz=%b, want q=ff dbz=1", quotient, dbz);
      end
      @(negedge clk);
      dividend = 8'd50;
      divisor  = 8'd5;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      nvec++;
      if (dbz !== 1'b0 || quotient !== 8'hFF || remainder !== 8'h64) begin
         nerr++;
         $display("FAIL dbz_clear: got dbz=%b q=%h r=%h, want dbz=0 q=ff r=64", dbz, quotient, remainder);
      end
      repeat (12) @(posedge clk);
      #1;
      nvec++;
      if (quotient !== 8'h0A || remainder !== 8'h00) begin
         nerr++;
         $display("FAIL dbz_next: got q=%h r=%h, want q=0a r=00", quotient, remainder);
      end
   endtask

   task automatic test_ovf_one();
      int lat;
      logic bz;
      run_op(8'h80, 8'hFF, lat, bz);
      nvec++;
      if (quotient !== 8'h80 || remainder !== 8'h00 || ovf !== 1'b1 || dbz !== 1'b0 || lat !== LAT_ONE) begin
         nerr++;
         $display("FAIL ovf: got q=%h r=%h ovf=%b dbz=%b lat=%0d, want q=80 r=00 ovf=1 dbz=0 lat=%0d",
                  quotient, remainder, ovf, dbz, lat, LAT_ONE);
      end
      run_op(8'h80, 8'd1, lat, bz);
      nvec++;
      if (quotient !== 8'h80 || remainder !== 8'h00 || ovf !== 1'b0 || lat !== LAT_ONE) begin
         nerr++;
         $display("FAIL div_plus1: got q=%h r=%h ovf=%b lat=%0d, want q=80 r=00 ovf=0 lat=%0d",
                  quotient, remainder, ovf, lat, LAT_ONE);
      end
      run_op(8'd37, 8'hFF, lat, bz);
      nvec++;
      if (quotient !== 8'hDB || remainder !== 8'h00 || ovf !== 1'b0 || lat !== LAT_ONE) begin
         nerr++;
         $display("FAIL div_minus1: got q=%h r=%h ovf=%b lat=%0d, want q=db r=00 ovf=0 lat=%0d",
                  quotient, remainder, ovf, lat, LAT_ONE);
      end
   endtask

   task automatic test_ignored_start();
      int lat;
      @(negedge clk);
      dividend = 8'd100;
      divisor  = 8'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = -1;
      for (int i = 1; i <= 40; i++) begin
         if (i == 4) begin
            dividend = 8'd9;
            divisor  = 8'd3;
            start    = 1'b1;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done) begin
            lat = i;
            break;
         end
      end
      nvec++;
      if (quotient !== 8'h0E || remainder !== 8'h02 || lat !== 11) begin
         nerr++;
         $display("FAIL ignored_start: got q=%h r=%h lat=%0d, want q=0e r=02 lat=11", quotient, remainder, lat);
      end
   endtask

   task automatic test_back_to_back();
      int first;
      int second;
      @(negedge clk);
      dividend = 8'd100;
      divisor  = 8'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      first  = -1;
      second = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            if (first < 0) begin
               first = i;
            end else begin
               second = i;
               start  = 1'b0;
               break;
            end
         end
      end
      start = 1'b0;
      nvec++;
      if (first !== 11 || second !== 23) begin
         nerr++;
         $display("FAIL back_to_back: got done at %0d and %0d, want 11 and 23", first, second);
      end
      repeat (2) @(posedge clk);
      #1;
      nvec++;
      if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'h0E) begin
         nerr++;
         $display("FAIL b2b_idle: got busy=%b done=%b q=%h, want busy=0 done=0 q=0e", busy, done, quotient);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      int lat;
      logic bz;
      @(negedge clk);
      dividend = 8'd100;
      divisor  = 8'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      nvec++;
      if ({quotient, remainder, busy, done, dbz, ovf} !== 20'h0) begin
         nerr++;
         $display("FAIL reset_mid: got q=%h r=%h busy=%b done=%b dbz=%b ovf=%b, want all 0",
                  quotient, remainder, busy, done, dbz, ovf);
      end
      @(negedge clk);
      reset = 1'b1;
      seen  = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) seen++;
      end
      nvec++;
      if (seen !== 0) begin
         nerr++;
         $display("FAIL reset_no_done: got %0d cycles with done/busy, want 0", seen);
      end
      run_op(8'd127, 8'h80, lat, bz);
      nvec++;
      if (quotient !== 8'h00 || remainder !== 8'h7F || lat !== 11) begin
         nerr++;
         $display("FAIL after_reset: got q=%h r=%h lat=%0d, want q=00 r=7f lat=11", quotient, remainder, lat);
      end
   endtask

   initial begin
      nvec     = 0;
      nerr     = 0;
      reset    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      test_reset();
      test_divide();
      test_dbz();
      test_ovf_one();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
